// File: rtl/tone_buzzer_pkg.sv
// Shared register map and control-bit positions for the I/O-mapped tone buzzer.
package buzzer_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DIV_LO = 2'd1;
  localparam logic [1:0] ADDR_DIV_HI = 2'd2;
  localparam logic [1:0] ADDR_DUR    = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;

  // Counter width for a prescaler of the given modulus; never narrower than one bit.
  function automatic int pre_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/tone_buzzer_if.sv
// CPU-side write port of the tone buzzer: active-low chip select and write strobe, address, data.
interface tone_buzzer_if #(
  parameter int DATA_W = 8
);
  logic              CS_N;
  logic              IOW_N;
  logic [1:0]        addr;
  logic [DATA_W-1:0] din;

  modport master (output CS_N, IOW_N, addr, din);
  modport slave  (input  CS_N, IOW_N, addr, din);
endinterface

// File: rtl/tone_buzzer_divider.sv
// Half-period counter: toggles the tone every div cycles while enabled, holds 0 otherwise.
module tone_divider #(
  parameter int DIV_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tone
);

  logic [DIV_W-1:0] cnt_r;
  logic             tone_r;
  logic             wrap_s;

  // Compare with >= so a divider shrunk below the running count wraps at once.
  always_comb begin
    wrap_s = 1'b0;
    if (div != '0) begin
      wrap_s = (cnt_r >= (div - DIV_W'(1)));
    end else begin
      wrap_s = 1'b0;
    end
  end

  // Count, wrap and toggle; disabled or zero divider parks everything at 0.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      tone_r <= 1'b0;
    end else if (!en || (div == '0)) begin
      cnt_r  <= '0;
      tone_r <= 1'b0;
    end else if (wrap_s) begin
      cnt_r  <= '0;
      tone_r <= ~tone_r;
    end else begin
      cnt_r  <= cnt_r + DIV_W'(1);
      tone_r <= tone_r;
    end
  end

  assign tone = tone_r;

endmodule

// File: rtl/tone_buzzer.sv
// Tone buzzer top: strobe edge detect, register file, one-shot duration timer and divider.
module tone_buzzer
  import buzzer_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DIV_W    = 16,
  parameter int DUR_W    = 8,
  parameter int PRESCALE = 50000
) (
  input  logic           clk_in,
  input  logic           rst_n,
  tone_buzzer_if.slave   bus,
  output logic           buzzer,
  output logic           busy
);

  localparam int               PRE_W    = pre_width(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic              wr_s;
  logic              wr_d_r;
  logic              commit_s;
  logic              ctrl_wr_s;
  logic              trigger_s;
  logic              tick_s;
  logic              div_en_s;
  logic              en_r;
  logic              oneshot_r;
  logic [DATA_W-1:0] shadow_lo_r;
  logic [DIV_W-1:0]  div_r;
  logic [DUR_W-1:0]  dur_r;
  logic [DUR_W-1:0]  dur_cnt_r;
  logic [PRE_W-1:0]  pre_cnt_r;

  // Decode the strobe; a one-shot trigger holds the divider off for one edge to restart its phase.
  always_comb begin
    wr_s      = ~bus.CS_N & ~bus.IOW_N;
    commit_s  = wr_s & ~wr_d_r;
    ctrl_wr_s = commit_s & (bus.addr == ADDR_CTRL);
    trigger_s = ctrl_wr_s & bus.din[CTRL_EN] & bus.din[CTRL_ONESHOT] & (dur_r != '0);
    tick_s    = en_r & oneshot_r & (pre_cnt_r == PRE_LAST);
    div_en_s  = en_r & ~trigger_s;
  end

  // Strobe history and the divider/duration registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wr_d_r      <= 1'b0;
      shadow_lo_r <= '0;
      div_r       <= '0;
      dur_r       <= '0;
    end else begin
      wr_d_r <= wr_s;
      if (commit_s) begin
        case (bus.addr)
          ADDR_DIV_LO: shadow_lo_r <= bus.din;
          ADDR_DIV_HI: div_r       <= DIV_W'({bus.din, shadow_lo_r});
          ADDR_DUR:    dur_r       <= bus.din[DUR_W-1:0];
          default:     div_r       <= div_r;
        endcase
      end
    end
  end

  // Control register and one-shot timer; a CTRL commit overrides a coincident expiry.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      en_r      <= 1'b0;
      oneshot_r <= 1'b0;
      dur_cnt_r <= '0;
      pre_cnt_r <= '0;
    end else if (ctrl_wr_s) begin
      oneshot_r <= bus.din[CTRL_ONESHOT];
      en_r      <= bus.din[CTRL_EN] & ~(bus.din[CTRL_ONESHOT] & (dur_r == '0));
      dur_cnt_r <= dur_r;
      pre_cnt_r <= '0;
    end else if (en_r && oneshot_r) begin
      if (tick_s) begin
        pre_cnt_r <= '0;
        dur_cnt_r <= dur_cnt_r - DUR_W'(1);
        en_r      <= (dur_cnt_r != DUR_W'(1));
      end else begin
        pre_cnt_r <= pre_cnt_r + PRE_W'(1);
      end
    end else begin
      pre_cnt_r <= '0;
    end
  end

  tone_divider #(
    .DIV_W (DIV_W)
  ) u_divider (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .en     (div_en_s),
    .div    (div_r),
    .tone   (buzzer)
  );

  assign busy = en_r;

endmodule

// File: tb/tb_tone_buzzer.sv
// Scoreboard bench for tone_buzzer: expected buzzer/busy per cycle are queued at each stimulus
// and popped on every falling clock edge.
module tb_tone_buzzer;
  import buzzer_pkg::*;

  localparam int PRESCALE = 4;

  logic clk_in = 1'b0;
  logic rst_n;
  logic buzzer;
  logic busy;

  tone_buzzer_if #(.DATA_W(8)) bus ();

  tone_buzzer #(
    .DATA_W   (8),
    .DIV_W    (16),
    .DUR_W    (8),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus),
    .buzzer (buzzer),
    .busy   (busy)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    string tag;
    logic  bz;
    logic  by;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int k, input logic bz, input logic by);
    exp_t e;
    e.tag = $sformatf("%s[%0d]", tag, k);
    e.bz  = bz;
    e.by  = by;
    sb_q.push_back(e);
  endtask

  task automatic sb_compare();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_pop_on_empty", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_val({e.tag, ".buzzer"}, 32'(buzzer), 32'(e.bz));
      check_val({e.tag, ".busy"},   32'(busy),   32'(e.by));
    end
  endtask

  task automatic check_trace(input int n);
    for (int i = 0; i < n; i++) begin
      sb_compare();
      @(negedge clk_in);
    end
  endtask

  // Tone of a divider started from rest, k cycles after the enabling commit.
  function automatic logic fresh_tone(input int k, input int d);
    return logic'((k / d) % 2);
  endfunction

  // One-cycle strobe; returns on the falling edge right after the commit edge (sample 0).
  task automatic do_write(input logic [1:0] a, input logic [7:0] d);
    bus.addr  = a;
    bus.din   = d;
    bus.CS_N  = 1'b0;
    bus.IOW_N = 1'b0;
    @(negedge clk_in);
    bus.CS_N  = 1'b1;
    bus.IOW_N = 1'b1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    do_write(a, d);
    @(negedge clk_in);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.CS_N  = 1'b1;
    bus.IOW_N = 1'b1;
    bus.addr  = 2'd0;
    bus.din   = 8'h00;
    repeat (2) @(negedge clk_in);
    push_exp("reset", 0, 1'b0, 1'b0);
    sb_compare();
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);

    // Continuous tone, DIV=3: first rise 3 cycles after commit, period 6.
    cfg_write(ADDR_DIV_LO, 8'h03);
    cfg_write(ADDR_DIV_HI, 8'h00);
    do_write(ADDR_CTRL, 8'h01);
    for (int k = 0; k < 21; k++) push_exp("cont3", k, fresh_tone(k, 3), 1'b1);
    check_trace(21);
    do_write(ADDR_CTRL, 8'h00);
    push_exp("stop", 0, 1'b1, 1'b0);
    for (int k = 1; k < 5; k++) push_exp("stop", k, 1'b0, 1'b0);
    check_trace(5);

    // Reset asserted while the buzzer is high, between clock edges.
    do_write(ADDR_CTRL, 8'h01);
    for (int k = 0; k < 5; k++) push_exp("pre_rst", k, fresh_tone(k, 3), 1'b1);
    check_trace(5);
    rst_n = 1'b0;
    #1;
    push_exp("rst_mid", 0, 1'b0, 1'b0);
    sb_compare();
    @(negedge clk_in);
    rst_n = 1'b1;
    @(negedge clk_in);

    // Registers cleared: DIV=0 gives a silent enabled tone, DUR=0 makes a one-shot a no-op.
    do_write(ADDR_CTRL, 8'h01);
    for (int k = 0; k < 12; k++) push_exp("div0", k, 1'b0, 1'b1);
    check_trace(12);
    do_write(ADDR_CTRL, 8'h03);
    for (int k = 0; k < 6; k++) push_exp("dur0_rst", k, 1'b0, 1'b0);
    check_trace(6);

    // Strobe held 10 cycles on a 2-unit one-shot: a single commit means busy ends at 8.
    cfg_write(ADDR_DIV_LO, 8'h03);
    cfg_write(ADDR_DIV_HI, 8'h00);
    cfg_write(ADDR_DUR, 8'h02);
    bus.addr  = ADDR_CTRL;
    bus.din   = 8'h03;
    bus.CS_N  = 1'b0;
    bus.IOW_N = 1'b0;
    @(negedge clk_in);
    for (int k = 0; k < 14; k++)
      push_exp("hold", k, (k <= 8) ? fresh_tone(k, 3) : 1'b0, logic'(k < 8));
    check_trace(10);
    bus.CS_N  = 1'b1;
    bus.IOW_N = 1'b1;
    check_trace(4);

    // DIV_LO alone keeps DIV=3; DIV_HI then commits DIV=5.
    cfg_write(ADDR_DIV_LO, 8'h05);
    do_write(ADDR_CTRL, 8'h01);
    for (int k = 0; k < 15; k++) push_exp("lo_only", k, fresh_tone(k, 3), 1'b1);
    check_trace(15);
    cfg_write(ADDR_CTRL, 8'h00);
    cfg_write(ADDR_DIV_HI, 8'h00);
    do_write(ADDR_CTRL, 8'h01);
    for (int k = 0; k < 22; k++) push_exp("div5", k, fresh_tone(k, 5), 1'b1);
    check_trace(22);
    cfg_write(ADDR_CTRL, 8'h00);

    // One-shot DUR=5: busy for exactly 20 cycles.
    cfg_write(ADDR_DIV_LO, 8'h03);
    cfg_write(ADDR_DIV_HI, 8'h00);
    cfg_write(ADDR_DUR, 8'h05);
    do_write(ADDR_CTRL, 8'h03);
    for (int k = 0; k < 26; k++)
      push_exp("shot5", k, (k <= 20) ? fresh_tone(k, 3) : 1'b0, logic'(k < 20));
    check_trace(26);
    cfg_write(ADDR_DUR, 8'h00);
    do_write(ADDR_CTRL, 8'h03);
    for (int k = 0; k < 6; k++) push_exp("dur0", k, 1'b0, 1'b0);
    check_trace(6);

    // Retrigger after 11 cycles; a DUR write during the run must not shorten it.
    cfg_write(ADDR_DUR, 8'h05);
    do_write(ADDR_CTRL, 8'h03);
    for (int k = 0; k < 10; k++) push_exp("retrig_a", k, fresh_tone(k, 3), 1'b1);
    check_trace(10);
    do_write(ADDR_CTRL, 8'h03);
    for (int k = 0; k < 5; k++) push_exp("retrig_b", k, fresh_tone(k, 3), 1'b1);
    check_trace(5);
    do_write(ADDR_DUR, 8'h01);
    for (int k = 6; k < 26; k++)
      push_exp("retrig_b", k, (k <= 20) ? fresh_tone(k, 3) : 1'b0, logic'(k < 20));
    check_trace(20);

    // CTRL commit on the very edge the 2-unit one-shot expires.
    cfg_write(ADDR_DUR, 8'h02);
    do_write(ADDR_CTRL, 8'h03);
    for (int k = 0; k < 7; k++) push_exp("expiry_a", k, fresh_tone(k, 3), 1'b1);
    check_trace(7);
    do_write(ADDR_CTRL, 8'h03);
    for (int k = 0; k < 11; k++)
      push_exp("expiry_b", k, (k <= 8) ? fresh_tone(k, 3) : 1'b0, logic'(k < 8));
    check_trace(11);

    // DIV 0x0100 shrunk to 0x0002 with cnt=13: wrap next cycle, then period 4.
    cfg_write(ADDR_DIV_LO, 8'h00);
    cfg_write(ADDR_DIV_HI, 8'h01);
    do_write(ADDR_CTRL, 8'h01);
    for (int k = 0; k < 10; k++) push_exp("div256", k, 1'b0, 1'b1);
    check_trace(10);
    cfg_write(ADDR_DIV_LO, 8'h02);
    do_write(ADDR_DIV_HI, 8'h00);
    push_exp("shrink", 0, 1'b0, 1'b1);
    for (int k = 1; k < 12; k++) push_exp("shrink", k, logic'(((k - 1) / 2) % 2 == 0), 1'b1);
    check_trace(12);
    cfg_write(ADDR_CTRL, 8'h00);

    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
